// File: rtl/id_eeprom_i2c_pkg.sv
// Shared types and register map for the board ID EEPROM I2C master.
package id_eeprom_i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP
    } state_t;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_CMD      = 2'd1;
    localparam logic [1:0] ADDR_STATUS   = 2'd2;
    localparam logic [1:0] ADDR_PRESCALE = 2'd3;

    localparam int unsigned CMD_STA  = 0;
    localparam int unsigned CMD_STO  = 1;
    localparam int unsigned CMD_WR   = 2;
    localparam int unsigned CMD_RD   = 3;
    localparam int unsigned CMD_NACK = 4;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_RX_NACK = 1;
    localparam int unsigned STAT_DONE    = 2;
    localparam int unsigned STAT_IEN     = 3;

endpackage

// File: rtl/id_eeprom_i2c_master_quarter_tick.sv
// Quarter-bit prescaler: reloads from prescale, fires tick on zero, freezes while hold is high.
module i2c_quarter_tick #(
    parameter int unsigned PRESCALE_RST = 124
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        hold,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] cnt;

    // While idle the counter tracks prescale so the first quarter of a command is full length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 16'(PRESCALE_RST);
        end else if (!run) begin
            cnt <= prescale;
        end else if (!hold) begin
            cnt <= (cnt == '0) ? prescale : cnt - 16'd1;
        end
    end

    assign tick = run & ~hold & (cnt == '0);

endmodule

// File: rtl/id_eeprom_i2c_master.sv
// Avalon-MM byte-level I2C master for the board ID EEPROM.
// Optional slave clock stretching is compiled in with `define I2C_CLK_STRETCH_EN.
module id_eeprom_i2c_master #(
    parameter int unsigned PRESCALE_RST = 124
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        scl_oe,
    output logic        sda_oe
);
    import id_eeprom_i2c_pkg::*;

    state_t      state, state_nxt;
    logic [1:0]  q, q_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic        scl_nxt, sda_nxt;
    logic [7:0]  rx_shift, shift_nxt;
    logic        rx_nack, nack_nxt;
    logic        complete;

    logic        busy, done, ien;
    logic [7:0]  txbyte, rxbyte;
    logic [15:0] prescale;
    logic        op_sto, op_wr, op_rd, op_nack;

    logic        wr_en, cmd_go, tick, hold;
    logic        unused_inputs;

    assign wr_en  = chipselect & ~write_n;
    assign cmd_go = wr_en && (address == ADDR_CMD) && !busy && (|writedata[3:0]);

    assign unused_inputs = ^{writedata[31:16], read_n, scl_in};

`ifdef I2C_CLK_STRETCH_EN
    assign hold = busy && (state != IDLE) && (q == 2'd2) && !scl_oe && !scl_in;
`else
    assign hold = 1'b0;
`endif

    i2c_quarter_tick #(
        .PRESCALE_RST(PRESCALE_RST)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (busy),
        .hold    (hold),
        .prescale(prescale),
        .tick    (tick)
    );

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        bit_nxt   = bit_idx;
        scl_nxt   = scl_oe;
        sda_nxt   = sda_oe;
        shift_nxt = rx_shift;
        nack_nxt  = rx_nack;
        complete  = 1'b0;

        if (cmd_go) begin
            q_nxt   = '0;
            bit_nxt = 3'd7;
            if (writedata[CMD_STA]) begin
                state_nxt = START;
            end else if (writedata[CMD_WR] | writedata[CMD_RD]) begin
                state_nxt = BIT;
            end else begin
                state_nxt = STOP;
            end
        end else if (tick) begin
            q_nxt = q + 2'd1;
            case (state)
                START: begin
                    case (q)
                        2'd0: sda_nxt = 1'b0;
                        2'd1: scl_nxt = 1'b0;
                        2'd2: sda_nxt = 1'b1;
                        default: begin
                            scl_nxt = 1'b1;
                            if (op_wr | op_rd) begin
                                state_nxt = BIT;
                            end else if (op_sto) begin
                                state_nxt = STOP;
                            end else begin
                                state_nxt = IDLE;
                                complete  = 1'b1;
                            end
                        end
                    endcase
                end
                BIT: begin
                    case (q)
                        2'd0: sda_nxt = op_wr ? ~txbyte[bit_idx] : 1'b0;
                        2'd1: scl_nxt = 1'b0;
                        2'd2: if (op_rd) shift_nxt = {rx_shift[6:0], sda_in};
                        default: begin
                            scl_nxt = 1'b1;
                            if (bit_idx == 3'd0) begin
                                state_nxt = ACK;
                            end else begin
                                bit_nxt = bit_idx - 3'd1;
                            end
                        end
                    endcase
                end
                ACK: begin
                    case (q)
                        2'd0: sda_nxt = op_wr ? 1'b0 : ~op_nack;
                        2'd1: scl_nxt = 1'b0;
                        2'd2: if (op_wr) nack_nxt = sda_in;
                        default: begin
                            scl_nxt = 1'b1;
                            if (op_sto) begin
                                state_nxt = STOP;
                            end else begin
                                state_nxt = IDLE;
                                complete  = 1'b1;
                            end
                        end
                    endcase
                end
                STOP: begin
                    case (q)
                        2'd0: sda_nxt = 1'b1;
                        2'd1: scl_nxt = 1'b0;
                        2'd2: sda_nxt = 1'b0;
                        default: begin
                            state_nxt = IDLE;
                            complete  = 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            q        <= '0;
            bit_idx  <= 3'd7;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            rx_shift <= '0;
            rx_nack  <= 1'b0;
        end else begin
            state    <= state_nxt;
            q        <= q_nxt;
            bit_idx  <= bit_nxt;
            scl_oe   <= scl_nxt;
            sda_oe   <= sda_nxt;
            rx_shift <= shift_nxt;
            rx_nack  <= nack_nxt;
        end
    end

    // Completion outranks a coincident done-clear write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            ien      <= 1'b0;
            txbyte   <= '0;
            rxbyte   <= '0;
            prescale <= 16'(PRESCALE_RST);
            op_sto   <= 1'b0;
            op_wr    <= 1'b0;
            op_rd    <= 1'b0;
            op_nack  <= 1'b0;
        end else begin
            if (wr_en && (address == ADDR_DATA)) txbyte <= writedata[7:0];
            if (wr_en && (address == ADDR_PRESCALE)) prescale <= writedata[15:0];
            if (wr_en && (address == ADDR_STATUS)) ien <= writedata[STAT_IEN];

            if (cmd_go) begin
                busy    <= 1'b1;
                op_sto  <= writedata[CMD_STO];
                op_wr   <= writedata[CMD_WR];
                op_rd   <= writedata[CMD_RD] & ~writedata[CMD_WR];
                op_nack <= writedata[CMD_NACK];
            end else if (complete) begin
                busy <= 1'b0;
            end

            if (complete) begin
                done <= 1'b1;
            end else if (cmd_go) begin
                done <= 1'b0;
            end else if (wr_en && (address == ADDR_STATUS) && writedata[STAT_DONE]) begin
                done <= 1'b0;
            end

            if (complete && op_rd) rxbyte <= rx_shift;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[7:0]  = rxbyte;
            ADDR_STATUS:   readdata[3:0]  = {ien, done, rx_nack, busy};
            ADDR_PRESCALE: readdata[15:0] = prescale;
            default:       ;
        endcase
    end

    assign irq = done & ien;

endmodule

// File: tb/tb_id_eeprom_i2c_master.sv
// Directed bench for id_eeprom_i2c_master with a behavioural I2C bus monitor and slave.
module tb_id_eeprom_i2c_master;
    import id_eeprom_i2c_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic        scl_in, sda_in, scl_oe, sda_oe;
    logic        slave_scl = 1'b1;
    logic        slave_sda = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign scl_in = ~scl_oe & slave_scl;
    assign sda_in = ~sda_oe & slave_sda;

    id_eeprom_i2c_master #(.PRESCALE_RST(124)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    // Bus monitor and slave state
    int          rise_count = 0;
    int          start_seen = 0;
    int          stop_seen = 0;
    logic [15:0] cap = '0;
    logic [8:0]  cap9 = '0;
    logic        ack_sda_oe = 1'b0;
    int          hi_len[16];
    time         t_rel = 0;
    bit          rd_mode = 1'b0;
    logic [7:0]  rd_byte = '0;
    logic        ack_val = 1'b0;
    bit          stretch_armed = 1'b0;

    function automatic logic value_for(input int k);
        if (rd_mode) return (k < 8) ? rd_byte[3'(7 - k)] : 1'b1;
        return (k == 8) ? ack_val : 1'b1;
    endfunction

    always @(posedge scl_in) begin
        cap = {cap[14:0], sda_in};
        rise_count++;
        if (rise_count == 9) begin
            cap9 = cap[8:0];
            ack_sda_oe = sda_oe;
        end
    end

    always @(negedge scl_in) begin
        slave_sda = value_for(rise_count);
        if (stretch_armed && rise_count == 2) slave_scl = 1'b0;
    end

    always @(negedge sda_in) if (scl_in === 1'b1) begin
        start_seen++;
        rise_count = 0;
        cap = '0;
    end

    always @(posedge sda_in) if (scl_in === 1'b1) stop_seen++;

    always @(negedge scl_oe) t_rel = $time;

    always @(posedge scl_oe) if (rise_count > 0 && rise_count < 17)
        hi_len[rise_count - 1] = int'(($time - t_rel) / 10);

    always @(negedge scl_oe) if (stretch_armed && !slave_scl) begin
        repeat (50) @(negedge clk);
        slave_scl = 1'b1;
        stretch_armed = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        #1 d = readdata;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic wait_idle(input int limit);
        logic [31:0] st;
        st = 32'h1;
        for (int n = 0; n < limit && st[0]; n++) cpu_read(ADDR_STATUS, st);
        check("busy_clears", 32'(st[0]), 32'h0);
    endtask

    task automatic arm(input bit rd, input logic [7:0] b, input logic ack);
        rd_mode = rd; rd_byte = b; ack_val = ack;
        rise_count = 0; cap = '0; cap9 = '0;
        slave_sda = value_for(0);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vec[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int s0, p0, n;

        vec[0] = '{wr:1'b0, waddr:ADDR_DATA,     wdata:32'h0,         raddr:ADDR_PRESCALE, exp:32'd124};
        vec[1] = '{wr:1'b0, waddr:ADDR_DATA,     wdata:32'h0,         raddr:ADDR_STATUS,   exp:32'h0};
        vec[2] = '{wr:1'b0, waddr:ADDR_DATA,     wdata:32'h0,         raddr:ADDR_DATA,     exp:32'h0};
        vec[3] = '{wr:1'b0, waddr:ADDR_DATA,     wdata:32'h0,         raddr:ADDR_CMD,      exp:32'h0};
        vec[4] = '{wr:1'b1, waddr:ADDR_PRESCALE, wdata:32'hFFFF_1234, raddr:ADDR_PRESCALE, exp:32'h1234};
        vec[5] = '{wr:1'b1, waddr:ADDR_STATUS,   wdata:32'h8,         raddr:ADDR_STATUS,   exp:32'h8};
        vec[6] = '{wr:1'b1, waddr:ADDR_DATA,     wdata:32'hA5,        raddr:ADDR_DATA,     exp:32'h0};
        vec[7] = '{wr:1'b1, waddr:ADDR_CMD,      wdata:32'h10,        raddr:ADDR_STATUS,   exp:32'h8};
        vec[8] = '{wr:1'b1, waddr:ADDR_STATUS,   wdata:32'hC,         raddr:ADDR_STATUS,   exp:32'h8};
        vec[9] = '{wr:1'b1, waddr:ADDR_PRESCALE, wdata:32'h3,         raddr:ADDR_PRESCALE, exp:32'h3};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_scl_oe", 32'(scl_oe), 32'h0);
        check("rst_sda_oe", 32'(sda_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        for (int i = 0; i < 10; i++) begin
            if (vec[i].wr) cpu_write(vec[i].waddr, vec[i].wdata);
            cpu_read(vec[i].raddr, rd);
            check($sformatf("reg_vec[%0d]", i), rd, vec[i].exp);
        end
        check("irq_idle", 32'(irq), 32'h0);

        // START + write 0xA0, slave ACKs
        arm(1'b0, 8'h00, 1'b0);
        s0 = start_seen;
        cpu_write(ADDR_DATA, 32'hA0);
        cpu_write(ADDR_CMD, 32'h5);
        wait_idle(400);
        check("wr_start_seen", 32'(start_seen - s0), 32'd1);
        check("wr_bits_ack", 32'(cap9), 32'h140);
        cpu_read(ADDR_STATUS, rd);
        check("wr_status", rd, 32'hC);
        check("wr_scl_held", 32'(scl_oe), 32'h1);
        check("wr_sda_rel", 32'(sda_oe), 32'h0);
        check("wr_irq", 32'(irq), 32'h1);
        check("wr_scl_high_len", 32'(hi_len[0]), 32'd8);
        cpu_write(ADDR_STATUS, 32'hC);
        cpu_read(ADDR_STATUS, rd);
        check("done_clear", rd, 32'h8);
        check("irq_cleared", 32'(irq), 32'h0);

        // Write 0x55 + STOP, slave NACKs
        arm(1'b0, 8'h00, 1'b1);
        s0 = start_seen; p0 = stop_seen;
        cpu_write(ADDR_DATA, 32'h55);
        cpu_write(ADDR_CMD, 32'h6);
        wait_idle(400);
        check("nack_bits", 32'(cap9), 32'h0AB);
        cpu_read(ADDR_STATUS, rd);
        check("nack_status", rd, 32'hE);
        check("nack_stop_seen", 32'(stop_seen - p0), 32'd1);
        check("nack_no_start", 32'(start_seen - s0), 32'd0);
        check("nack_scl_rel", 32'(scl_oe), 32'h0);
        check("nack_sda_rel", 32'(sda_oe), 32'h0);

        // START alone, then read 0x5A with master NACK + STOP
        s0 = start_seen;
        cpu_write(ADDR_CMD, 32'h1);
        wait_idle(400);
        check("sta_only_start", 32'(start_seen - s0), 32'd1);
        check("sta_only_scl", 32'(scl_oe), 32'h1);
        arm(1'b1, 8'h5A, 1'b1);
        p0 = stop_seen;
        cpu_write(ADDR_CMD, 32'h1A);
        wait_idle(400);
        cpu_read(ADDR_DATA, rd);
        check("rd_data", rd, 32'h5A);
        cpu_read(ADDR_STATUS, rd);
        check("rd_status", rd, 32'hE);
        check("rd_bus_bits", 32'(cap9), 32'h0B5);
        check("rd_ack_released", 32'(ack_sda_oe), 32'h0);
        check("rd_irq", 32'(irq), 32'h1);
        check("rd_stop_seen", 32'(stop_seen - p0), 32'd1);

        // PRESCALE=0: 36 busy cycles for WR+ACK; CMD during busy ignored
        cpu_write(ADDR_PRESCALE, 32'h0);
        cpu_write(ADDR_CMD, 32'h1);
        wait_idle(100);
        arm(1'b0, 8'h00, 1'b0);
        s0 = start_seen;
        cpu_write(ADDR_DATA, 32'h3C);
        cpu_write(ADDR_CMD, 32'h4);
        cpu_write(ADDR_CMD, 32'hB);
        n = 1;
        rd = 32'h1;
        for (int k = 0; k < 200 && rd[0]; k++) begin
            cpu_read(ADDR_STATUS, rd);
            if (rd[0]) n++;
        end
        check("fast_busy_cycles", 32'(n), 32'd36);
        check("fast_status", rd, 32'hC);
        check("fast_bits", 32'(cap9), 32'h078);
        check("fast_no_start", 32'(start_seen - s0), 32'd0);
        cpu_read(ADDR_DATA, rd);
        check("ignored_cmd_rxbyte", rd, 32'h5A);

        // Reset in the middle of bit 4
        cpu_write(ADDR_PRESCALE, 32'h3);
        arm(1'b0, 8'h00, 1'b0);
        cpu_write(ADDR_DATA, 32'h00);
        cpu_write(ADDR_CMD, 32'h4);
        for (int k = 0; k < 500 && !(rise_count == 4 && scl_in == 1'b0); k++) @(negedge clk);
        check("bit4_reached", 32'(rise_count), 32'd4);
        check("mid_scl_low", 32'(scl_oe), 32'h1);
        check("mid_sda_low", 32'(sda_oe), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_scl_rel", 32'(scl_oe), 32'h0);
        check("async_sda_rel", 32'(sda_oe), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cpu_read(ADDR_PRESCALE, rd);
        check("post_rst_prescale", rd, 32'd124);
        cpu_read(ADDR_STATUS, rd);
        check("post_rst_status", rd, 32'h0);

`ifdef I2C_CLK_STRETCH_EN
        // Slave stretches bit 5 (third bit) low for 50 cycles
        cpu_write(ADDR_PRESCALE, 32'h3);
        cpu_write(ADDR_CMD, 32'h1);
        wait_idle(400);
        arm(1'b0, 8'h00, 1'b0);
        stretch_armed = 1'b1;
        cpu_write(ADDR_DATA, 32'h96);
        cpu_write(ADDR_CMD, 32'h4);
        wait_idle(600);
        check("stretch_normal_high", 32'(hi_len[1]), 32'd8);
        check("stretch_extended_high", 32'(hi_len[2]), 32'd58);
        check("stretch_bits", 32'(cap9), 32'h12C);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
